// File: rtl/reverser_16_if.sv
// Operand/result bundle for reverser_16: operand side driven by the master,
// registered permuted result returned by the slave.
interface reverser_16_if;
    logic [15:0] in;
    logic        in_valid;
    logic [1:0]  mode;
    logic [15:0] out;
    logic        out_valid;

    modport master (
        output in,
        output in_valid,
        output mode,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in,
        input  in_valid,
        input  mode,
        output out,
        output out_valid
    );
endinterface

// File: rtl/reverser_16.sv
// Registered 16-bit bit-order permutation unit (full/byte-wise reverse, byte swap).
// Define REVERSER16_NIBBLE_MODE_EN to make mode 2'b11 a nibble-wise reverse instead of pass-through.
module reverser_16 (
    input logic           clk,
    input logic           rst_n,
    reverser_16_if.slave  bus
);
    logic [15:0] full_rev;
    logic [15:0] byte_rev;
    logic [15:0] perm;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_full
            assign full_rev[gi] = bus.in[15 - gi];
        end
        for (gi = 0; gi < 8; gi++) begin : g_byte
            assign byte_rev[gi]     = bus.in[7 - gi];
            assign byte_rev[8 + gi] = bus.in[15 - gi];
        end
    endgenerate

`ifdef REVERSER16_NIBBLE_MODE_EN
    logic [15:0] nib_rev;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nib_rev[4*gi + 0] = bus.in[4*gi + 3];
            assign nib_rev[4*gi + 1] = bus.in[4*gi + 2];
            assign nib_rev[4*gi + 2] = bus.in[4*gi + 1];
            assign nib_rev[4*gi + 3] = bus.in[4*gi + 0];
        end
    endgenerate
`endif

    always_comb begin
        perm = bus.in;
        case (bus.mode)
            2'b00:   perm = full_rev;
            2'b01:   perm = byte_rev;
            2'b10:   perm = {bus.in[7:0], bus.in[15:8]};
`ifdef REVERSER16_NIBBLE_MODE_EN
            default: perm = nib_rev;
`else
            default: perm = bus.in;
`endif
        endcase
    end

    // out holds its last value on idle cycles; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= 16'h0000;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out <= perm;
            end
        end
    end
endmodule

// File: tb/tb_reverser_16.sv
// Self-checking bench for reverser_16: streaming-operator reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_reverser_16;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    logic [15:0] exp_out;
    logic        exp_valid;

`ifdef REVERSER16_NIBBLE_MODE_EN
    localparam logic [15:0] MODE3_1234 = 16'h84C2;
`else
    localparam logic [15:0] MODE3_1234 = 16'h1234;
`endif

    reverser_16_if bus ();

    reverser_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte- and nibble-wise reversal are a full reversal followed by
    // restoring the original byte/nibble order.
    function automatic logic [15:0] model(input logic [15:0] x, input logic [1:0] m);
        logic [15:0] r;
        logic [15:0] b;
        r = {<<{x}};
        case (m)
            2'b00:   b = r;
            2'b01:   b = {<<8{r}};
            2'b10:   b = {x[7:0], x[15:8]};
`ifdef REVERSER16_NIBBLE_MODE_EN
            default: b = {<<4{r}};
`else
            default: b = x;
`endif
        endcase
        return b;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out   = 16'h0000;
            exp_valid = 1'b0;
        end else begin
            exp_valid = bus.in_valid;
            if (bus.in_valid) exp_out = model(bus.in, bus.mode);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out_valid", {15'd0, bus.out_valid}, {15'd0, exp_valid});
            check("model_out", bus.out, exp_out);
        end
    end

    task automatic send(input logic [15:0] x, input logic [1:0] m);
        bus.in       = x;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string name, input logic [15:0] val, input logic vld);
        check({name, "_out"}, bus.out, val);
        check({name, "_valid"}, {15'd0, bus.out_valid}, {15'd0, vld});
    endtask

    logic [15:0] vec_in   [8] = '{16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hC3A5,
                                  16'h7001, 16'hFFFE, 16'h5A5A, 16'h0100};
    logic [1:0]  vec_mode [8] = '{2'b00, 2'b01, 2'b10, 2'b11,
                                  2'b00, 2'b11, 2'b01, 2'b10};

    initial begin
        check("pin_rev_00aa", model(16'h00AA, 2'b00), 16'h5500);
        check("pin_rev_1234", model(16'h1234, 2'b00), 16'h2C48);
        check("pin_byterev",  model(16'h1234, 2'b01), 16'h482C);
        check("pin_swap",     model(16'h1234, 2'b10), 16'h3412);
        check("pin_mode3",    model(16'h1234, 2'b11), MODE3_1234);

        bus.in       = 16'h1234;
        bus.in_valid = 1'b1;
        bus.mode     = 2'b00;
        #1 rst_n = 1'b0;
        #2;
        expect_res("reset_async", 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        expect_res("reset_held", 16'h0000, 1'b0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        cmp_en       = 1'b1;
        idle();
        expect_res("post_reset_idle", 16'h0000, 1'b0);

        send(16'h00AA, 2'b00); expect_res("rev_00aa", 16'h5500, 1'b1);
        send(16'h1234, 2'b00); expect_res("rev_1234", 16'h2C48, 1'b1);
        send(16'h1234, 2'b01); expect_res("byterev_1234", 16'h482C, 1'b1);
        send(16'h1234, 2'b10); expect_res("swap_1234", 16'h3412, 1'b1);
        send(16'h1234, 2'b11); expect_res("mode3_1234", MODE3_1234, 1'b1);
        idle();                expect_res("idle_hold", MODE3_1234, 1'b0);

        bus.in   = 16'hFFFF;
        bus.mode = 2'b01;
        idle();                expect_res("ignore_when_invalid", MODE3_1234, 1'b0);

        send(16'h0001, 2'b00); expect_res("stream0", 16'h8000, 1'b1);
        send(16'h8000, 2'b00); expect_res("stream1", 16'h0001, 1'b1);
        send(16'hF00F, 2'b00); expect_res("stream2", 16'hF00F, 1'b1);
        idle();                expect_res("stream_drop", 16'hF00F, 1'b0);

        send(16'h8001, 2'b00); expect_res("pal_8001", 16'h8001, 1'b1);
        send(16'hFFFF, 2'b00); expect_res("pal_ffff", 16'hFFFF, 1'b1);
        send(16'h0000, 2'b00); expect_res("pal_0000", 16'h0000, 1'b1);

        for (int i = 0; i < 8; i++) begin
            send(vec_in[i], vec_mode[i]);
        end
        idle();

        send(16'hABCD, 2'b10); expect_res("pre_rst_swap", 16'hCDAB, 1'b1);
        bus.in       = 16'h1357;
        bus.mode     = 2'b00;
        bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        expect_res("midstream_rst", 16'h0000, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_res("inflight_dropped", 16'h0000, 1'b0);
        send(16'h1357, 2'b00); expect_res("after_rst_rev", 16'hEAC8, 1'b1);
        idle();
        idle();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
